// File: rtl/dmem_lane_responder.sv
// rtl/dmem_lane_responder.sv - word SRAM responder with lane-merged stores and extended loads
// Optional DMEM_ALIGN_CHECK_EN: lane code vs ReqAddr[1:0] check, suppressing mismatched accesses.
module dmem_lane_responder #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [2:0]  WriteMemDataLength,
  input  logic [3:0]  ReadMemExtSignal,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        AddrError
);

  localparam logic [2:0] DWORD        = 3'd0;
  localparam logic [2:0] WORD_HIGH    = 3'd1;
  localparam logic [2:0] WORD_LOW     = 3'd2;
  localparam logic [2:0] BYTE_HIGHEST = 3'd3;
  localparam logic [2:0] BYTE_HIGH    = 3'd4;
  localparam logic [2:0] BYTE_LOW     = 3'd5;
  localparam logic [2:0] BYTE_LOWEST  = 3'd6;

  localparam logic [3:0] U_DWORD        = 4'd0;
  localparam logic [3:0] S_WORD_HIGH    = 4'd1;
  localparam logic [3:0] S_WORD_LOW     = 4'd2;
  localparam logic [3:0] U_WORD_HIGH    = 4'd3;
  localparam logic [3:0] U_WORD_LOW     = 4'd4;
  localparam logic [3:0] S_BYTE_HIGHEST = 4'd5;
  localparam logic [3:0] S_BYTE_HIGH    = 4'd6;
  localparam logic [3:0] S_BYTE_LOW     = 4'd7;
  localparam logic [3:0] S_BYTE_LOWEST  = 4'd8;
  localparam logic [3:0] U_BYTE_HIGHEST = 4'd9;
  localparam logic [3:0] U_BYTE_HIGH    = 4'd10;
  localparam logic [3:0] U_BYTE_LOW     = 4'd11;
  localparam logic [3:0] U_BYTE_LOWEST  = 4'd12;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t                  state;
  logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DEPTH_LOG2-1:0]   ld_idx;
  logic [3:0]              ld_code;
  logic                    ld_err;
  logic                    mis;
  logic                    wr_en;
  logic [3:0]              be;
  logic [31:0]             wd;
  logic                    unused_addr;

  assign idx         = ReqAddr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{ReqAddr[31:DEPTH_LOG2+2], ReqAddr[1:0]};
  assign ReqReady    = (state == IDLE);
  assign wr_en       = ReqValid & ReqReady & ReqWrite & ~mis;

`ifdef DMEM_ALIGN_CHECK_EN
  // {check applies, required ReqAddr[1:0]}; undefined codes are never flagged
  function automatic logic [2:0] wr_align(input logic [2:0] c);
    case (c)
      DWORD, WORD_LOW, BYTE_LOWEST: wr_align = 3'b100;
      WORD_HIGH, BYTE_HIGH:         wr_align = 3'b110;
      BYTE_LOW:                     wr_align = 3'b101;
      BYTE_HIGHEST:                 wr_align = 3'b111;
      default:                      wr_align = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] rd_align(input logic [3:0] c);
    case (c)
      U_DWORD, S_WORD_LOW, U_WORD_LOW, S_BYTE_LOWEST, U_BYTE_LOWEST: rd_align = 3'b100;
      S_WORD_HIGH, U_WORD_HIGH, S_BYTE_HIGH, U_BYTE_HIGH:            rd_align = 3'b110;
      S_BYTE_LOW, U_BYTE_LOW:                                        rd_align = 3'b101;
      S_BYTE_HIGHEST, U_BYTE_HIGHEST:                                rd_align = 3'b111;
      default:                                                       rd_align = 3'b000;
    endcase
  endfunction

  logic [2:0] req_align;
  assign req_align = ReqWrite ? wr_align(WriteMemDataLength) : rd_align(ReadMemExtSignal);
  assign mis       = req_align[2] & (req_align[1:0] != ReqAddr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Replicated data lets each byte enable pick its lane without a shifter
  always_comb begin
    be = 4'b0000;
    wd = {2{ReqWData[15:0]}};
    case (WriteMemDataLength)
      DWORD:        begin be = 4'b1111; wd = ReqWData; end
      WORD_HIGH:    be = 4'b1100;
      WORD_LOW:     be = 4'b0011;
      BYTE_HIGHEST: begin be = 4'b1000; wd = {4{ReqWData[7:0]}}; end
      BYTE_HIGH:    begin be = 4'b0100; wd = {4{ReqWData[7:0]}}; end
      BYTE_LOW:     begin be = 4'b0010; wd = {4{ReqWData[7:0]}}; end
      BYTE_LOWEST:  begin be = 4'b0001; wd = {4{ReqWData[7:0]}}; end
      default:      be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [3:0] c);
    case (c)
      U_DWORD:        extract = w;
      S_WORD_HIGH:    extract = {{16{w[31]}}, w[31:16]};
      S_WORD_LOW:     extract = {{16{w[15]}}, w[15:0]};
      U_WORD_HIGH:    extract = {16'h0, w[31:16]};
      U_WORD_LOW:     extract = {16'h0, w[15:0]};
      S_BYTE_HIGHEST: extract = {{24{w[31]}}, w[31:24]};
      S_BYTE_HIGH:    extract = {{24{w[23]}}, w[23:16]};
      S_BYTE_LOW:     extract = {{24{w[15]}}, w[15:8]};
      S_BYTE_LOWEST:  extract = {{24{w[7]}}, w[7:0]};
      U_BYTE_HIGHEST: extract = {24'h0, w[31:24]};
      U_BYTE_HIGH:    extract = {24'h0, w[23:16]};
      U_BYTE_LOW:     extract = {24'h0, w[15:8]};
      U_BYTE_LOWEST:  extract = {24'h0, w[7:0]};
      default:        extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      RespValid <= 1'b0;
      RespData  <= 32'h0;
      AddrError <= 1'b0;
      ld_idx    <= '0;
      ld_code   <= 4'h0;
      ld_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            if (ReqWrite) begin
              state     <= RESP;
              RespValid <= 1'b1;
              RespData  <= 32'h0;
              AddrError <= mis;
            end else begin
              state   <= RD;
              ld_idx  <= idx;
              ld_code <= ReadMemExtSignal;
              ld_err  <= mis;
            end
          end
        end
        RD: begin
          state     <= RESP;
          RespValid <= 1'b1;
          RespData  <= ld_err ? 32'h0 : extract(mem[ld_idx], ld_code);
          AddrError <= ld_err;
        end
        RESP: begin
          state     <= IDLE;
          RespValid <= 1'b0;
          RespData  <= 32'h0;
          AddrError <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane_responder.sv
// tb/tb_dmem_lane_responder.sv - scoreboard bench for dmem_lane_responder
// Honours DMEM_ALIGN_CHECK_EN for the misalignment expectations.
module tb_dmem_lane_responder;

  localparam logic [2:0] DWORD = 3'd0, WORD_HIGH = 3'd1, WORD_LOW = 3'd2, BYTE_HIGHEST = 3'd3,
                         BYTE_HIGH = 3'd4, BYTE_LOWEST = 3'd6, WL_BAD = 3'd7;
  localparam logic [3:0] U_DWORD = 4'd0, S_WORD_HIGH = 4'd1, U_WORD_LOW = 4'd4,
                         S_BYTE_HIGHEST = 4'd5, S_BYTE_HIGH = 4'd6, S_BYTE_LOWEST = 4'd8,
                         U_BYTE_HIGH = 4'd10, U_BYTE_LOWEST = 4'd12, RX_BAD = 4'd15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [31:0] ReqAddr = 32'h0;
  logic [31:0] ReqWData = 32'h0;
  logic [2:0]  WriteMemDataLength = 3'd0;
  logic [3:0]  ReadMemExtSignal = 4'd0;
  logic        RespValid;
  logic [31:0] RespData;
  logic        AddrError;

  dmem_lane_responder #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rstn(rstn),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .WriteMemDataLength(WriteMemDataLength), .ReadMemExtSignal(ReadMemExtSignal),
    .RespValid(RespValid), .RespData(RespData), .AddrError(AddrError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response and checks data, flag and arrival cycle
  always @(negedge clk) begin
    if (rstn) begin
      if (RespValid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("resp_data", RespData, e.data);
          check("resp_err", {31'h0, AddrError}, {31'h0, e.err});
          check("resp_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_data_zero", RespData, 32'h0);
      end
    end
  end

  // Drives one request (caller is away from the clock edge); returns acceptance cycle
  task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] wl, input logic [3:0] rx,
                     input logic [31:0] edata, input logic eerr,
                     input bit keep, input bit push, output int acc);
    int n;
    n = 0;
    acc = -1;
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = addr; ReqWData = wdata;
    WriteMemDataLength = wl; ReadMemExtSignal = rx;
    while (!ReqReady && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ReqReady) begin
      check("accept_timeout", 32'd0, 32'd1);
      ReqValid = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      if (push) sbq.push_back('{edata, eerr, wr ? cyc : cyc + 1});
      if (!keep) ReqValid = 1'b0;
    end
  endtask

  initial begin
    int a0, a1, a2, a3, a4;
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, a4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ReqReady}, 32'd1);
    check("rst_valid", {31'h0, RespValid}, 32'd0);
    check("rst_data", RespData, 32'h0);
    check("rst_err", {31'h0, AddrError}, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic word round trip and ready-low window for a load
    req(1, 32'h10, 32'hDEADBEEF, DWORD, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h10, 32'h0, DWORD, U_DWORD, 32'hDEADBEEF, 0, 0, 1, a0);
    check("ld_ready_low0", {31'h0, ReqReady}, 32'd0);
    @(posedge clk); #1;
    check("ld_ready_low1", {31'h0, ReqReady}, 32'd0);
    @(posedge clk); #1;
    check("ld_ready_back", {31'h0, ReqReady}, 32'd1);

    // Byte lane merge with signed/unsigned extraction
    req(1, 32'h10, 32'h00000000, DWORD, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(1, 32'h12, 32'h12345680, BYTE_HIGH, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h10, 32'h0, DWORD, U_DWORD, 32'h00800000, 0, 0, 1, a0);
    req(0, 32'h12, 32'h0, DWORD, S_BYTE_HIGH, 32'hFFFFFF80, 0, 0, 1, a0);
    req(0, 32'h12, 32'h0, DWORD, U_BYTE_HIGH, 32'h00000080, 0, 0, 1, a0);

    // Halfword merge; upper address bits alias into the same word
    req(1, 32'h20, 32'h11112222, DWORD, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(1, 32'h22, 32'hAAAA8001, WORD_HIGH, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h10000020, 32'h0, DWORD, U_DWORD, 32'h80012222, 0, 0, 1, a0);
    req(0, 32'h22, 32'h0, DWORD, S_WORD_HIGH, 32'hFFFF8001, 0, 0, 1, a0);
    req(0, 32'h20, 32'h0, DWORD, U_WORD_LOW, 32'h00002222, 0, 0, 1, a0);

    // Undefined store code writes nothing; undefined load code returns raw word
    req(1, 32'h20, 32'h5A5A5A5A, WL_BAD, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h20, 32'h0, DWORD, RX_BAD, 32'h80012222, 0, 0, 1, a0);
    req(1, 32'h20, 32'h0000007F, BYTE_LOWEST, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h20, 32'h0, DWORD, S_BYTE_LOWEST, 32'h0000007F, 0, 0, 1, a0);

    // Back-to-back with ReqValid held: store every 2 cycles, load every 3
    req(1, 32'h40, 32'h01020304, DWORD, U_DWORD, 32'h0, 0, 1, 1, a0);
    req(0, 32'h40, 32'h0, DWORD, U_BYTE_LOWEST, 32'h00000004, 0, 1, 1, a1);
    req(1, 32'h43, 32'h000000F0, BYTE_HIGHEST, U_DWORD, 32'h0, 0, 1, 1, a2);
    req(0, 32'h43, 32'h0, DWORD, S_BYTE_HIGHEST, 32'hFFFFFFF0, 0, 1, 1, a3);
    req(0, 32'h40, 32'h0, DWORD, U_DWORD, 32'hF0020304, 0, 0, 1, a4);
    check("gap_store_load", a1 - a0, 32'd2);
    check("gap_load_store", a2 - a1, 32'd3);
    check("gap_store_load2", a3 - a2, 32'd2);
    check("gap_load_load", a4 - a3, 32'd3);
    repeat (3) @(posedge clk); #1;

    // Reset during RD aborts the load; the next load completes normally
    req(0, 32'h40, 32'h0, DWORD, U_DWORD, 32'h0, 0, 0, 0, a0);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_valid", {31'h0, RespValid}, 32'd0);
    check("abort_ready", {31'h0, ReqReady}, 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    req(0, 32'h40, 32'h0, DWORD, U_DWORD, 32'hF0020304, 0, 0, 1, a0);

    // Misaligned WORD_LOW store and misaligned load
    req(1, 32'h50, 32'h55667788, DWORD, U_DWORD, 32'h0, 0, 0, 1, a0);
`ifdef DMEM_ALIGN_CHECK_EN
    req(1, 32'h53, 32'h0000ABCD, WORD_LOW, U_DWORD, 32'h0, 1, 0, 1, a0);
    req(0, 32'h50, 32'h0, DWORD, U_DWORD, 32'h55667788, 0, 0, 1, a0);
    req(0, 32'h51, 32'h0, DWORD, U_WORD_LOW, 32'h0, 1, 0, 1, a0);
`else
    req(1, 32'h53, 32'h0000ABCD, WORD_LOW, U_DWORD, 32'h0, 0, 0, 1, a0);
    req(0, 32'h50, 32'h0, DWORD, U_DWORD, 32'h5566ABCD, 0, 0, 1, a0);
    req(0, 32'h51, 32'h0, DWORD, U_WORD_LOW, 32'h0000ABCD, 0, 0, 1, a0);
`endif

    repeat (5) @(posedge clk); #1;
    check("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_lane_responder.md
# dmem_lane_responder

Data-memory responder at the far end of the MEM-stage load/store interface. It accepts a request carrying the byte address, raw store data and the lane codes produced by the ALU (`WriteMemDataLength` for stores, `ReadMemExtSignal` for loads). For stores it merges the data into a word-organised SRAM with per-byte enables. For loads it extracts and sign- or zero-extends the selected byte, halfword or word into a 32-bit writeback value, using a valid/ready handshake so the pipeline can stall on it.

## Interface

Parameters:
- `DEPTH_LOG2`, 10: SRAM holds 2^DEPTH_LOG2 32-bit words; word index = `ReqAddr[DEPTH_LOG2+1:2]`, upper address bits ignored.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  responder can accept; high only in IDLE.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqAddr`  in  32  byte address (ALU result).
- `ReqWData`  in  32  unshifted rt value; byte in [7:0], halfword in [15:0].
- `WriteMemDataLength`  in  3  store lane code (`DWORD`, `WORD_HIGH/LOW`, `BYTE_HIGHEST/HIGH/LOW/LOWEST` from ControlSignalDefine.v).
- `ReadMemExtSignal`  in  4  load extract code (`U_DWORD`, `S/U_WORD_HIGH/LOW`, `S/U_BYTE_*`).
- `RespValid`  out  1  one-cycle pulse; response complete.
- `RespData`  out  32  extended load data; 0 for store acknowledge.
- `AddrError`  out  1  alignment mismatch flag, valid with `RespValid` (see Configuration).

## Operation

- FSM states: IDLE, RD (SRAM read in flight), RESP.
- IDLE → RD on `ReqValid & ~ReqWrite`. IDLE → RESP on `ReqValid & ReqWrite`. RD → RESP unconditionally. RESP → IDLE unconditionally.
- Acceptance occurs on the edge where `ReqValid & ReqReady`. All request fields are sampled there and are don't-care afterwards.
- Store lane placement:
  - BYTE_LOWEST/LOW/HIGH/HIGHEST writes `ReqWData[7:0]` into byte 0/1/2/3.
  - WORD_LOW/HIGH writes `ReqWData[15:0]` into bytes 1:0 / 3:2.
  - DWORD writes all 4 bytes.
  - Unwritten bytes keep their value.
  - Any undefined code writes no bytes.
- Store commits on the acceptance edge.
- Load extraction: the selected byte or half of the registered read word is moved to bit 0.
  - `S_*` codes replicate the selected MSB into the upper bits.
  - `U_*` codes zero-fill the upper bits.
  - `U_DWORD` passes the word through.
  - An undefined code returns the raw word.
- `RespData` is registered and is driven only while in RESP. It is 0 otherwise.
- No backpressure on the response. The consumer must take it in the RESP cycle.
- Reset values: state IDLE, `ReqReady`=1 once `rstn` is high, `RespValid`=0, `RespData`=0, `AddrError`=0. SRAM contents are not reset.
- Reset asserted in RD or RESP aborts the operation: no `RespValid`. A store already committed stays committed.

## Timing

- Store accepted at edge N: SRAM updated at N; `RespValid`=1 in cycle N+1; `ReqReady`=1 again in N+2.
- Load accepted at edge N: SRAM read at N+1; `RespValid`=1 with data in cycle N+2; `ReqReady`=1 again in N+3.
- Throughput: one store per 2 cycles, one load per 3 cycles.
- Read-after-write: a load accepted after a store's RESP cycle returns the merged data. No forwarding is needed, since requests never overlap.
- `ReqReady` is a pure function of state, with no combinational path from `ReqValid`.

## Configuration

- `DMEM_ALIGN_CHECK_EN`
  - Defined: at acceptance, the lane code is compared with `ReqAddr[1:0]`.
    - Byte codes require an exact match.
    - WORD_HIGH requires 2'b10 and WORD_LOW requires 2'b00.
    - DWORD/U_DWORD require 2'b00.
  - On mismatch: the store is suppressed (no bytes written), a load returns 0, and `AddrError`=1 during RESP.
  - Undefined: no check is made, `AddrError` is tied to 0, and only the code selects lanes.

## Test plan

- Reset then DWORD store 0xDEADBEEF to 0x10, then `U_DWORD` load from 0x10. Expected: `RespData`=0xDEADBEEF in cycle N+2; `ReqReady` low for exactly 2 cycles.
- BYTE_HIGH store of `ReqWData`=0x12345680 to 0x12 over 0x00000000. Expected: word = 0x00800000. Then `S_BYTE_HIGH` load returns 0xFFFFFF80 and `U_BYTE_HIGH` load returns 0x00000080.
- WORD_HIGH store 0xAAAA8001 to 0x22 over 0x11112222. Expected: word = 0x80012222. Then `S_WORD_HIGH` returns 0xFFFF8001 and `U_WORD_LOW` returns 0x00002222.
- Hold `ReqValid`=1 continuously with alternating store/load. Expected: exactly one acceptance per IDLE cycle and no dropped or duplicated `RespValid`.
- Assert `rstn`=0 during RD, release it, then issue a new load. Expected: no `RespValid` for the aborted load; the new load completes at N+2.
- With `DMEM_ALIGN_CHECK_EN`: WORD_LOW store to 0x03. Expected: memory unchanged, `AddrError`=1 with `RespValid`. Without the macro, the same stimulus writes bytes 1:0 and `AddrError`=0.
